// File: rtl/xadc_drp_responder.sv
// XADC DRP responder and aux4/aux12 conversion sequencer.
// Stands in for the XADC primitive; samples are injected through ports.
module xadc_drp_responder #(
    parameter int READ_LATENCY = 4,
    parameter int CONV_CYCLES  = 26
) (
    input  logic        xadc_dclk,
    input  logic        xadc_reset,
    input  logic        den,
    input  logic        dwe,
    input  logic [6:0]  daddr,
    input  logic [15:0] di,
    output logic [15:0] do_data,
    output logic        drdy,
    output logic        eoc,
    output logic        eos,
    output logic [4:0]  channel,
    output logic        busy,
    input  logic [11:0] aux4_sample,
    input  logic        aux4_sample_valid,
    input  logic [11:0] aux12_sample,
    input  logic        aux12_sample_valid,
    output logic        protocol_error
);

    localparam logic [6:0] ADDR_AUX4  = 7'h14;
    localparam logic [6:0] ADDR_AUX12 = 7'h1C;
    localparam logic [6:0] ADDR_CFG0  = 7'h40;
    localparam logic [6:0] ADDR_CFG1  = 7'h41;
    localparam logic [6:0] ADDR_CFG2  = 7'h42;

    localparam logic [4:0] CH_AUX4  = 5'd4;
    localparam logic [4:0] CH_AUX12 = 5'd12;

    localparam int CW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CONV_CYCLES - 2);

    localparam bit            LAT_ONE  = (READ_LATENCY == 1);
    localparam logic [3:0]    LAT_INIT = 4'(READ_LATENCY - 1);

    logic [CW-1:0] conv_cnt;
    logic          conv_last;

    logic [11:0]   stage_aux4;
    logic [11:0]   stage_aux12;
    logic [11:0]   stat_aux4;
    logic [11:0]   stat_aux12;
    logic [15:0]   cfg0;
    logic [15:0]   cfg1;
    logic [15:0]   cfg2;

    logic          pend;
    logic [3:0]    lat_cnt;
    logic          cap_we;
    logic [6:0]    cap_addr;
    logic [15:0]   cap_wdata;
    logic [15:0]   cap_rdata;

    logic [15:0]   rd_val;
    logic          drp_busy;
    logic          accept;
    logic          finish;
    logic          fin_we;
    logic [6:0]    fin_addr;
    logic [15:0]   fin_wdata;
    logic [15:0]   fin_rdata;

    assign conv_last = (conv_cnt == CNT_LAST);

    // Register read mux over the current (pre-edge) register contents
    always_comb begin
        rd_val = 16'h0000;
        case (daddr)
            ADDR_AUX4:  rd_val = {stat_aux4, 4'b0000};
            ADDR_AUX12: rd_val = {stat_aux12, 4'b0000};
            ADDR_CFG0:  rd_val = cfg0;
            ADDR_CFG1:  rd_val = cfg1;
            ADDR_CFG2:  rd_val = cfg2;
            default:    rd_val = 16'h0000;
        endcase
    end

    // Transaction accept and completion; latency 1 completes straight from the inputs
    always_comb begin
        drp_busy = pend | drdy;
        accept   = den & ~drp_busy;
        if (LAT_ONE) begin
            finish    = accept;
            fin_we    = dwe;
            fin_addr  = daddr;
            fin_wdata = di;
            fin_rdata = rd_val;
        end else begin
            finish    = pend && (lat_cnt == 4'd1);
            fin_we    = cap_we;
            fin_addr  = cap_addr;
            fin_wdata = cap_wdata;
            fin_rdata = cap_rdata;
        end
    end

    // Conversion counter, channel rotation and eoc/eos/busy strobes
    always_ff @(posedge xadc_dclk) begin
        if (xadc_reset) begin
            conv_cnt <= '0;
            channel  <= CH_AUX4;
            eoc      <= 1'b0;
            eos      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            conv_cnt <= conv_last ? '0 : conv_cnt + 1'b1;
            busy     <= ~conv_last;
            eoc      <= (conv_cnt == CNT_PRE);
            eos      <= (conv_cnt == CNT_PRE) && (channel == CH_AUX12);
            if (conv_last) begin
                channel <= (channel == CH_AUX4) ? CH_AUX12 : CH_AUX4;
            end
        end
    end

    // Staging loads on valid; status loads at end of its channel's eoc cycle
    always_ff @(posedge xadc_dclk) begin
        if (xadc_reset) begin
            stage_aux4  <= '0;
            stage_aux12 <= '0;
            stat_aux4   <= '0;
            stat_aux12  <= '0;
        end else begin
            if (aux4_sample_valid) begin
                stage_aux4 <= aux4_sample;
            end
            if (aux12_sample_valid) begin
                stage_aux12 <= aux12_sample;
            end
            if (conv_last && channel == CH_AUX4) begin
                stat_aux4 <= aux4_sample_valid ? aux4_sample : stage_aux4;
            end
            if (conv_last && channel == CH_AUX12) begin
                stat_aux12 <= aux12_sample_valid ? aux12_sample : stage_aux12;
            end
        end
    end

    // DRP transaction tracking, read data, config writes and error flag
    always_ff @(posedge xadc_dclk) begin
        if (xadc_reset) begin
            pend           <= 1'b0;
            lat_cnt        <= '0;
            cap_we         <= 1'b0;
            cap_addr       <= '0;
            cap_wdata      <= '0;
            cap_rdata      <= '0;
            drdy           <= 1'b0;
            do_data        <= '0;
            protocol_error <= 1'b0;
            cfg0           <= '0;
            cfg1           <= '0;
            cfg2           <= '0;
        end else begin
            drdy    <= 1'b0;
            do_data <= '0;
            if (den && drp_busy) begin
                protocol_error <= 1'b1;
            end
            if (accept && !LAT_ONE) begin
                pend      <= 1'b1;
                lat_cnt   <= LAT_INIT;
                cap_we    <= dwe;
                cap_addr  <= daddr;
                cap_wdata <= di;
                cap_rdata <= rd_val;
            end else if (pend) begin
                if (lat_cnt == 4'd1) begin
                    pend <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end
            if (finish) begin
                drdy    <= 1'b1;
                do_data <= fin_we ? 16'h0000 : fin_rdata;
                if (fin_we) begin
                    case (fin_addr)
                        ADDR_CFG0: cfg0 <= fin_wdata;
                        ADDR_CFG1: cfg1 <= fin_wdata;
                        ADDR_CFG2: cfg2 <= fin_wdata;
                        default:   ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Bench for xadc_drp_responder: directed scenarios plus random traffic
// checked against a cycle-indexed reference model.
module tb_xadc_drp_responder;

    localparam int LAT = 4;
    localparam int C   = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [6:0]  daddr = '0;
    logic [15:0] di = '0;
    logic [15:0] do_data;
    logic        drdy;
    logic        eoc;
    logic        eos;
    logic [4:0]  channel;
    logic        busy;
    logic [11:0] s4 = '0;
    logic        v4 = 1'b0;
    logic [11:0] s12 = '0;
    logic        v12 = 1'b0;
    logic        perr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    xadc_drp_responder #(.READ_LATENCY(LAT), .CONV_CYCLES(C)) dut (
        .xadc_dclk(clk),
        .xadc_reset(rst),
        .den(den),
        .dwe(dwe),
        .daddr(daddr),
        .di(di),
        .do_data(do_data),
        .drdy(drdy),
        .eoc(eoc),
        .eos(eos),
        .channel(channel),
        .busy(busy),
        .aux4_sample(s4),
        .aux4_sample_valid(v4),
        .aux12_sample(s12),
        .aux12_sample_valid(v12),
        .protocol_error(perr)
    );

    // Reference model: m_t is the 1-based cycle index since the last reset edge
    int          m_t = 0;
    logic [11:0] m_stg [2];
    logic [11:0] m_st [2];
    logic [15:0] m_cfg [3];
    bit          m_pend = 0;
    int          m_due = 0;
    bit          m_wr = 0;
    logic [6:0]  m_addr = '0;
    logic [15:0] m_wd = '0;
    logic [15:0] m_rd = '0;
    bit          m_perr = 0;

    function automatic logic [15:0] m_read(input logic [6:0] a);
        if (a == 7'h14) return {m_st[0], 4'h0};
        if (a == 7'h1C) return {m_st[1], 4'h0};
        if (a >= 7'h40 && a <= 7'h42) return m_cfg[int'(a) - 64];
        return 16'h0000;
    endfunction

    task automatic model_edge();
        bit was_busy;
        int idx;
        if (rst) begin
            m_t = 1;
            for (int i = 0; i < 2; i++) begin
                m_stg[i] = '0;
                m_st[i]  = '0;
            end
            for (int i = 0; i < 3; i++) m_cfg[i] = '0;
            m_pend = 0;
            m_perr = 0;
            return;
        end
        was_busy = m_pend;
        if (m_pend && m_t == m_due) m_pend = 0;
        if (den) begin
            if (was_busy) begin
                m_perr = 1;
            end else begin
                m_pend = 1;
                m_due  = m_t + LAT;
                m_wr   = dwe;
                m_addr = daddr;
                m_wd   = di;
                m_rd   = m_read(daddr);
            end
        end
        if (m_t % C == 0) begin
            idx = ((m_t - 1) / C) % 2;
            if (idx == 0) m_st[0] = v4 ? s4 : m_stg[0];
            else m_st[1] = v12 ? s12 : m_stg[1];
        end
        if (v4) m_stg[0] = s4;
        if (v12) m_stg[1] = s12;
        m_t++;
        if (m_pend && m_t == m_due && m_wr && m_addr >= 7'h40 && m_addr <= 7'h42)
            m_cfg[int'(m_addr) - 64] = m_wd;
    endtask

    function automatic logic [25:0] exp_vec();
        bit          dr = m_pend && (m_t == m_due);
        logic [15:0] d  = (dr && !m_wr) ? m_rd : 16'h0000;
        bit          e  = (m_t % C) == 0;
        logic [4:0]  ch = (((m_t - 1) / C) % 2 == 1) ? 5'd12 : 5'd4;
        bit          b  = ((m_t - 1) % C) != 0;
        return {dr, d, e, e && (ch == 5'd12), ch, b, m_perr};
    endfunction

    function automatic logic [25:0] got_vec();
        return {drdy, do_data, eoc, eos, channel, busy, perr};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drp_txn(input logic we, input logic [6:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd);
        den = 1'b1;
        dwe = we;
        daddr = a;
        di = d;
        tick();
        den = 1'b0;
        dwe = 1'b0;
        lat = 1;
        while (drdy !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        rd = do_data;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (got_vec() !== {1'b0, 16'h0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got %h expected %h", got_vec(),
                     {1'b0, 16'h0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_first_eoc();
        int w;
        int lat;
        logic [15:0] rd;
        s4 = 12'hABC;
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        s4 = '0;
        w = 0;
        while (eoc !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        n_checks++;
        if (m_t != C || channel !== 5'd4 || eos !== 1'b0)
            $display("FAIL first_eoc: got cycle %0d ch %0d eos %b expected cycle %0d ch 4 eos 0",
                     m_t, channel, eos, C);
        else n_pass++;
        tick();
        drp_txn(1'b0, 7'h14, 16'h0, lat, rd);
        n_checks++;
        if (lat != LAT || rd !== 16'hABC0)
            $display("FAIL read_aux4: got lat %0d data %h expected lat %0d data abc0", lat, rd, LAT);
        else n_pass++;
        drp_txn(1'b0, 7'h1C, 16'h0, lat, rd);
        n_checks++;
        if (lat != LAT || rd !== 16'h0000)
            $display("FAIL read_aux12: got lat %0d data %h expected lat %0d data 0000", lat, rd, LAT);
        else n_pass++;
    endtask

    task automatic test_regs();
        int lat;
        logic [15:0] rd;
        logic [15:0] r1;
        logic [15:0] r2;
        drp_txn(1'b1, 7'h40, 16'h1234, lat, rd);
        n_checks++;
        if (lat != LAT || rd !== 16'h0000)
            $display("FAIL write_cfg0: got lat %0d data %h expected lat %0d data 0000", lat, rd, LAT);
        else n_pass++;
        drp_txn(1'b0, 7'h40, 16'h0, lat, rd);
        n_checks++;
        if (lat != LAT || rd !== 16'h1234)
            $display("FAIL read_cfg0: got lat %0d data %h expected lat %0d data 1234", lat, rd, LAT);
        else n_pass++;
        drp_txn(1'b1, 7'h14, 16'hFFFF, lat, rd);
        n_checks++;
        if (lat != LAT)
            $display("FAIL write_ro_drdy: got lat %0d expected %0d", lat, LAT);
        else n_pass++;
        drp_txn(1'b0, 7'h14, 16'h0, lat, rd);
        n_checks++;
        if (lat != LAT || rd !== 16'hABC0)
            $display("FAIL read_ro_after_write: got lat %0d data %h expected abc0", lat, rd);
        else n_pass++;
        drp_txn(1'b1, 7'h3F, 16'h5A5A, lat, rd);
        drp_txn(1'b0, 7'h3F, 16'h0, lat, rd);
        n_checks++;
        if (lat != LAT || rd !== 16'h0000)
            $display("FAIL read_unmapped: got lat %0d data %h expected 0000", lat, rd);
        else n_pass++;
        r1 = 16'($urandom);
        r2 = 16'($urandom);
        drp_txn(1'b1, 7'h41, r1, lat, rd);
        drp_txn(1'b1, 7'h42, r2, lat, rd);
        drp_txn(1'b0, 7'h41, 16'h0, lat, rd);
        n_checks++;
        if (rd !== r1) $display("FAIL read_cfg1: got %h expected %h", rd, r1);
        else n_pass++;
        drp_txn(1'b0, 7'h42, 16'h0, lat, rd);
        n_checks++;
        if (rd !== r2) $display("FAIL read_cfg2: got %h expected %h", rd, r2);
        else n_pass++;
    endtask

    task automatic test_free_run();
        int eoc_t[$];
        logic [4:0] eoc_ch[$];
        int eos_t[$];
        int idle;
        bit ok;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle = 0;
        while (m_t <= 4 * C) begin
            n_checks++;
            if (got_vec() !== exp_vec())
                $display("FAIL free_run t=%0d: got %h expected %h", m_t, got_vec(), exp_vec());
            else n_pass++;
            if (eoc === 1'b1) begin
                eoc_t.push_back(m_t);
                eoc_ch.push_back(channel);
            end
            if (eos === 1'b1) eos_t.push_back(m_t);
            if (busy === 1'b0) idle++;
            tick();
        end
        ok = (eoc_t.size() == 4) && (eos_t.size() == 2);
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                if (eoc_t[k] != (k + 1) * C) ok = 0;
                if (eoc_ch[k] !== ((k % 2 == 0) ? 5'd4 : 5'd12)) ok = 0;
            end
            if (eos_t[0] != 2 * C || eos_t[1] != 4 * C) ok = 0;
        end
        n_checks++;
        if (!ok)
            $display("FAIL eoc_schedule: got %0d eoc and %0d eos expected 4 eoc and 2 eos at 26/52/78/104",
                     eoc_t.size(), eos_t.size());
        else n_pass++;
        n_checks++;
        if (idle != 4) $display("FAIL busy_idle_cycles: got %0d expected 4", idle);
        else n_pass++;
    endtask

    task automatic test_bypass();
        int w;
        int lat;
        logic [15:0] rd;
        s12 = 12'h321;
        v12 = 1'b1;
        tick();
        v12 = 1'b0;
        w = 0;
        while (!(eoc === 1'b1 && channel === 5'd12) && w < 200) begin
            tick();
            w++;
        end
        tick();
        w = 0;
        while (!(eoc === 1'b1 && channel === 5'd12) && w < 200) begin
            tick();
            w++;
        end
        s12 = 12'h555;
        v12 = 1'b1;
        den = 1'b1;
        dwe = 1'b0;
        daddr = 7'h1C;
        tick();
        v12 = 1'b0;
        den = 1'b0;
        lat = 1;
        while (drdy !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        rd = do_data;
        tick();
        n_checks++;
        if (lat != LAT || rd !== 16'h3210)
            $display("FAIL bypass_same_cycle_read: got lat %0d data %h expected lat %0d data 3210", lat, rd, LAT);
        else n_pass++;
        drp_txn(1'b0, 7'h1C, 16'h0, lat, rd);
        n_checks++;
        if (rd !== 16'h5550) $display("FAIL bypass_status: got %h expected 5550", rd);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            v4 = ($urandom_range(0, 7) == 0);
            s4 = 12'($urandom);
            v12 = ($urandom_range(0, 7) == 0);
            s12 = 12'($urandom);
            den = ($urandom_range(0, 3) == 0);
            dwe = 1'($urandom_range(0, 1));
            di = 16'($urandom);
            case ($urandom_range(0, 5))
                0: daddr = 7'h14;
                1: daddr = 7'h1C;
                2: daddr = 7'h40;
                3: daddr = 7'h41;
                4: daddr = 7'h42;
                default: daddr = 7'($urandom);
            endcase
            tick();
            n_checks++;
            if (got_vec() !== exp_vec())
                $display("FAIL random t=%0d: got %h expected %h", m_t, got_vec(), exp_vec());
            else n_pass++;
        end
        v4 = 1'b0;
        v12 = 1'b0;
        den = 1'b0;
        dwe = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset_mid();
        int w;
        int drdys;
        int lat;
        logic [15:0] rd;
        den = 1'b1;
        dwe = 1'b0;
        daddr = 7'h41;
        tick();
        den = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (perr !== 1'b0 || channel !== 5'd4 || busy !== 1'b0 || drdy !== 1'b0)
            $display("FAIL reset_mid_state: got perr %b ch %0d busy %b drdy %b expected 0 4 0 0",
                     perr, channel, busy, drdy);
        else n_pass++;
        drdys = 0;
        w = 0;
        while (eoc !== 1'b1 && w < 100) begin
            if (drdy === 1'b1) drdys++;
            tick();
            w++;
        end
        n_checks++;
        if (drdys != 0) $display("FAIL reset_mid_no_drdy: got %0d pulses expected 0", drdys);
        else n_pass++;
        n_checks++;
        if (m_t != C || channel !== 5'd4)
            $display("FAIL reset_mid_first_eoc: got cycle %0d ch %0d expected %0d ch 4", m_t, channel, C);
        else n_pass++;
        tick();
        drp_txn(1'b0, 7'h41, 16'h0, lat, rd);
        n_checks++;
        if (rd !== 16'h0000) $display("FAIL reset_mid_cfg1: got %h expected 0000", rd);
        else n_pass++;
        drp_txn(1'b0, 7'h14, 16'h0, lat, rd);
        n_checks++;
        if (rd !== 16'h0000) $display("FAIL reset_mid_aux4: got %h expected 0000", rd);
        else n_pass++;
    endtask

    task automatic test_protocol_error();
        int lat;
        int cnt;
        int at;
        logic [15:0] rd;
        logic [15:0] seen;
        drp_txn(1'b1, 7'h41, 16'hBEEF, lat, rd);
        n_checks++;
        if (lat != LAT || perr !== 1'b0)
            $display("FAIL perr_setup: got lat %0d perr %b expected lat %0d perr 0", lat, perr, LAT);
        else n_pass++;
        den = 1'b1;
        dwe = 1'b0;
        daddr = 7'h41;
        tick();
        daddr = 7'h14;
        tick();
        den = 1'b0;
        cnt = 0;
        at = 0;
        seen = '0;
        for (int i = 2; i < 12; i++) begin
            if (drdy === 1'b1) begin
                cnt++;
                seen = do_data;
                at = i;
            end
            tick();
        end
        n_checks++;
        if (cnt != 1 || seen !== 16'hBEEF || at != LAT)
            $display("FAIL overlap_single_drdy: got %0d pulses data %h at %0d expected 1 beef at %0d",
                     cnt, seen, at, LAT);
        else n_pass++;
        n_checks++;
        if (perr !== 1'b1) $display("FAIL perr_set: got %b expected 1", perr);
        else n_pass++;
        drp_txn(1'b0, 7'h40, 16'h0, lat, rd);
        n_checks++;
        if (perr !== 1'b1 || lat != LAT)
            $display("FAIL perr_sticky: got perr %b lat %0d expected perr 1 lat %0d", perr, lat, LAT);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (perr !== 1'b0) $display("FAIL perr_cleared: got %b expected 0", perr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_eoc();
        test_regs();
        test_free_run();
        test_bypass();
        test_random();
        test_reset_mid();
        test_protocol_error();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
